// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding, kernel constants and window packing for the 3x3 scheduler
package conv_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_KICK,
        S_MAC,
        S_WAIT,
        S_OUT
    } state_t;

    localparam int KERNEL_TAPS = 9;
    localparam int WAIT_MAX    = 4;
    localparam int PIX_W       = 8;
    localparam int WIN_W       = KERNEL_TAPS * PIX_W;

    // Pixel (r,c) of a window sits at [lsb+7:lsb], row-major starting with p00 at bit 0.
    function automatic int pix_lsb(input int r, input int c);
        return (r * 3 + c) * PIX_W;
    endfunction
endpackage

// File: rtl/conv3x3_raster_ctr.sv
// rtl/conv3x3_raster_ctr.sv - output-raster row/col and filter counters with wrap and last flags
module conv3x3_raster_ctr #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int NUM_FILT = 4,
    parameter int R_W      = 5,
    parameter int C_W      = 5,
    parameter int FI_W     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clear,
    input  logic            i_advance,
    output logic [FI_W-1:0] o_filt,
    output logic [R_W-1:0]  o_row,
    output logic [C_W-1:0]  o_col,
    output logic            o_last_filt,
    output logic            o_last_win
);
    logic [FI_W-1:0] r_filt;
    logic [R_W-1:0]  r_row;
    logic [C_W-1:0]  r_col;
    logic            w_last_filt;
    logic            w_last_col;
    logic            w_last_row;

    assign w_last_filt = (r_filt == FI_W'(NUM_FILT - 1));
    assign w_last_col  = (r_col == C_W'(IMG_W - 3));
    assign w_last_row  = (r_row == R_W'(IMG_H - 3));

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_filt <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (i_advance) begin
            if (!w_last_filt) begin
                r_filt <= r_filt + 1'b1;
            end else begin
                r_filt <= '0;
                if (!w_last_col) begin
                    r_col <= r_col + 1'b1;
                end else begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end
            end
        end
    end

    assign o_filt      = r_filt;
    assign o_row       = r_row;
    assign o_col       = r_col;
    assign o_last_filt = w_last_filt;
    assign o_last_win  = w_last_filt && w_last_col && w_last_row;
endmodule

// File: rtl/conv3x3_sched.sv
// rtl/conv3x3_sched.sv - sequencer: window fetch, engine kick, weight streaming and result handoff
module conv3x3_sched
    import conv_pkg::*;
#(
    parameter int  IMG_W    = 28,
    parameter int  IMG_H    = 28,
    parameter int  NUM_FILT = 4,
    localparam int WA_W     = $clog2(NUM_FILT * KERNEL_TAPS),
    localparam int FI_W     = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1,
    localparam int R_W      = $clog2(IMG_H),
    localparam int C_W      = $clog2(IMG_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               win_req,
    output logic [R_W-1:0]     win_row,
    output logic [C_W-1:0]     win_col,
    input  logic               win_vld,
    input  logic [71:0]        win_data,
    output logic [71:0]        eng_pix,
    output logic               eng_conv_en,
    output logic               eng_valid_in,
    input  logic               eng_valid_out,
    input  logic signed [15:0] eng_out,
    output logic               wrom_en,
    output logic [WA_W-1:0]    wrom_addr,
    output logic [FI_W-1:0]    bias_sel,
    output logic               res_valid,
    input  logic               res_ready,
    output logic signed [15:0] res_data,
    output logic [FI_W-1:0]    res_filt,
    output logic [R_W-1:0]     res_row,
    output logic [C_W-1:0]     res_col
);
    localparam int WD_W = $clog2(WAIT_MAX) + 1;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_step;
    logic [WD_W-1:0]    r_wd;
    logic               r_err;
    logic               r_done;
    logic [WIN_W-1:0]   r_pix;
    logic signed [15:0] r_res_data;
    logic [FI_W-1:0]    r_res_filt;
    logic [R_W-1:0]     r_res_row;
    logic [C_W-1:0]     r_res_col;

    logic [FI_W-1:0]    w_filt;
    logic [R_W-1:0]     w_row;
    logic [C_W-1:0]     w_col;
    logic               w_last_filt;
    logic               w_last_win;
    logic               w_accept;
    logic               w_hs;
    logic               w_capture;
    logic               w_timeout;
    logic [WA_W-1:0]    w_addr;

    // A start in the done cycle is dropped so a frame cannot be re-armed by its own completion.
    assign w_accept  = (r_state == S_IDLE) && start && !r_done;
    assign w_hs      = (r_state == S_OUT) && res_ready;
    assign w_capture = (r_state == S_WAIT) && eng_valid_out;
    assign w_timeout = (r_state == S_WAIT) && !eng_valid_out && (r_wd == WD_W'(WAIT_MAX - 1));
    assign w_addr    = WA_W'(w_filt) * WA_W'(KERNEL_TAPS)
                     + ((r_state == S_KICK) ? '0 : WA_W'(r_step));

    conv3x3_raster_ctr #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .NUM_FILT (NUM_FILT),
        .R_W      (R_W),
        .C_W      (C_W),
        .FI_W     (FI_W)
    ) u_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_accept),
        .i_advance   (w_hs),
        .o_filt      (w_filt),
        .o_row       (w_row),
        .o_col       (w_col),
        .o_last_filt (w_last_filt),
        .o_last_win  (w_last_win)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_FETCH;
            S_FETCH: if (win_vld) w_next = S_KICK;
            S_KICK:  w_next = S_MAC;
            S_MAC:   if (r_step == 4'(KERNEL_TAPS - 1)) w_next = S_WAIT;
            S_WAIT: begin
                if (eng_valid_out)  w_next = S_OUT;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_OUT: begin
                if (res_ready) begin
                    if (!w_last_filt)   w_next = S_KICK;
                    else if (w_last_win) w_next = S_IDLE;
                    else                 w_next = S_FETCH;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        win_req      = 1'b0;
        win_row      = '0;
        win_col      = '0;
        eng_conv_en  = 1'b0;
        eng_valid_in = 1'b0;
        wrom_en      = 1'b0;
        wrom_addr    = '0;
        bias_sel     = '0;
        res_valid    = 1'b0;
        case (r_state)
            S_FETCH: begin
                busy    = 1'b1;
                win_req = 1'b1;
                win_row = w_row;
                win_col = w_col;
            end
            S_KICK: begin
                busy         = 1'b1;
                eng_conv_en  = 1'b1;
                eng_valid_in = 1'b1;
                wrom_en      = 1'b1;
                wrom_addr    = w_addr;
                bias_sel     = w_filt;
            end
            S_MAC: begin
                busy        = 1'b1;
                eng_conv_en = 1'b1;
                wrom_en     = 1'b1;
                wrom_addr   = w_addr;
                bias_sel    = w_filt;
            end
            S_WAIT: begin
                busy        = 1'b1;
                eng_conv_en = 1'b1;
                bias_sel    = w_filt;
            end
            S_OUT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step     <= '0;
            r_wd       <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            r_pix      <= '0;
            r_res_data <= '0;
            r_res_filt <= '0;
            r_res_row  <= '0;
            r_res_col  <= '0;
        end else begin
            r_done <= w_timeout || (w_hs && w_last_win);
            if (w_accept)       r_err <= 1'b0;
            else if (w_timeout) r_err <= 1'b1;
            if (r_state == S_KICK)     r_step <= 4'd1;
            else if (r_state == S_MAC) r_step <= r_step + 4'd1;
            r_wd <= (r_state == S_WAIT) ? r_wd + 1'b1 : '0;
            if (r_state == S_FETCH && win_vld) r_pix <= win_data;
            if (w_capture) begin
                r_res_data <= eng_out;
                r_res_filt <= w_filt;
                r_res_row  <= w_row;
                r_res_col  <= w_col;
            end
        end
    end

    assign done     = r_done;
    assign err      = r_err;
    assign eng_pix  = r_pix;
    assign res_data = r_res_data;
    assign res_filt = r_res_filt;
    assign res_row  = r_res_row;
    assign res_col  = r_res_col;
endmodule

// File: tb/tb_conv3x3_sched.sv
// tb/tb_conv3x3_sched.sv - self-checking bench for conv3x3_sched with engine, ROM and window source models
module tb_conv3x3_sched;
    import conv_pkg::*;

    localparam int TW   = 4;
    localparam int TH   = 4;
    localparam int TF   = 2;
    localparam int OW   = TW - 2;
    localparam int OH   = TH - 2;
    localparam int WA_W = $clog2(TF * 9);
    localparam int FI_W = (TF > 1) ? $clog2(TF) : 1;
    localparam int R_W  = $clog2(TH);
    localparam int C_W  = $clog2(TW);

    typedef struct {
        int pix;
        int w0;
        int w1;
        int b0;
        int b1;
        int exp0;
        int exp1;
    } vec_t;

    typedef struct {
        int data;
        int filt;
        int row;
        int col;
    } res_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               busy, done, err, win_req;
    logic [R_W-1:0]     win_row;
    logic [C_W-1:0]     win_col;
    logic               win_vld = 1'b0;
    logic [71:0]        win_data = '0;
    logic [71:0]        eng_pix;
    logic               eng_conv_en, eng_valid_in;
    logic               eng_valid_out = 1'b0;
    logic signed [15:0] eng_out = '0;
    logic               wrom_en;
    logic [WA_W-1:0]    wrom_addr;
    logic [FI_W-1:0]    bias_sel;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic signed [15:0] res_data;
    logic [FI_W-1:0]    res_filt;
    logic [R_W-1:0]     res_row;
    logic [C_W-1:0]     res_col;

    conv3x3_sched #(.IMG_W(TW), .IMG_H(TH), .NUM_FILT(TF)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .win_req(win_req), .win_row(win_row), .win_col(win_col), .win_vld(win_vld),
        .win_data(win_data), .eng_pix(eng_pix), .eng_conv_en(eng_conv_en),
        .eng_valid_in(eng_valid_in), .eng_valid_out(eng_valid_out), .eng_out(eng_out),
        .wrom_en(wrom_en), .wrom_addr(wrom_addr), .bias_sel(bias_sel),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_filt(res_filt), .res_row(res_row), .res_col(res_col)
    );

    always #5 clk = ~clk;

    int   img [TH][TW];
    int   wts [TF*9];
    int   bias [TF];
    res_t sb [$];
    res_t mon_e;
    int   addr_q [$];
    int   n_pass = 0, n_tot = 0;
    int   cyc = 0, n_done = 0, t_done = 0, n_kick = 0, t_kick = 0, n_res = 0, t_hs = 0;
    int   n_winreq = 0, w_cnt = 0, last_req_len = 0, t_vld = 0, win_delay = 0, n_rom_bad = 0;
    int   e_ph = 0, e_acc = 0;
    bit   e_on = 0, eng_dead = 0, rdy_force = 0, rdy_val = 0, rdy_rand = 0, log_addr = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [71:0] pack_win(input int r, input int c);
        logic [71:0] d = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (r + i < TH && c + j < TW) d[pix_lsb(i, j) +: 8] = 8'(img[r+i][c+j]);
        return d;
    endfunction

    // Expected raster: row-major windows, filter innermost, value = bias + sum(w*p) wrapped to 16 bits.
    task automatic model_fill();
        logic signed [15:0] t16;
        int acc;
        sb.delete();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                for (int f = 0; f < TF; f++) begin
                    acc = bias[f];
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            acc += wts[f*9 + i*3 + j] * img[r+i][c+j];
                    t16 = 16'(acc);
                    sb.push_back('{int'(t16), f, r, c});
                end
    endtask

    // Environment: window source, synchronous ROM + engine, downstream sink and scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            win_vld       = 1'b0;
            eng_valid_out = 1'b0;
            e_on          = 1'b0;
            w_cnt         = 0;
        end else begin
            if (win_req) begin
                if (w_cnt == 0) n_winreq++;
                w_cnt++;
                if (w_cnt >= win_delay + 1) begin
                    win_vld  = 1'b1;
                    win_data = pack_win(int'(win_row), int'(win_col));
                    if (w_cnt == win_delay + 1) begin
                        last_req_len = w_cnt;
                        t_vld        = cyc;
                    end
                end else begin
                    win_vld = 1'b0;
                end
            end else begin
                win_vld = 1'b0;
                w_cnt   = 0;
            end

            if (eng_valid_in) begin
                n_kick++;
                t_kick = cyc;
                e_on   = 1'b1;
                e_ph   = 0;
                e_acc  = bias[int'(bias_sel)];
            end
            eng_valid_out = 1'b0;
            if (e_on) begin
                if (e_ph <= 8) begin
                    if (wrom_en && int'(wrom_addr) < TF*9)
                        e_acc += wts[int'(wrom_addr)] * int'(eng_pix[8*e_ph +: 8]);
                    else
                        n_rom_bad++;
                end else if (e_ph == 10) begin
                    e_on = 1'b0;
                    if (!eng_dead) begin
                        eng_valid_out = 1'b1;
                        eng_out       = 16'(e_acc);
                    end
                end
                e_ph++;
            end
            if (wrom_en) begin
                if (int'(wrom_addr) >= TF*9) n_rom_bad++;
                if (log_addr) addr_q.push_back(int'(wrom_addr));
            end

            res_ready = rdy_force ? rdy_val : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            if (res_valid && res_ready) begin
                n_res++;
                t_hs = cyc;
                if (sb.size() == 0) begin
                    chk("res_unexpected", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("res_data", int'(res_data), mon_e.data);
                    chk("res_filt", int'(res_filt), mon_e.filt);
                    chk("res_row",  int'(res_row),  mon_e.row);
                    chk("res_col",  int'(res_col),  mon_e.col);
                end
            end
            if (done) begin
                n_done++;
                t_done = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_done"},      int'(done), 0);
        chk({tag, "_err"},       int'(err), 0);
        chk({tag, "_win_req"},   int'(win_req), 0);
        chk({tag, "_eng_ctl"},   int'({eng_conv_en, eng_valid_in, wrom_en}), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_addrs"},     int'({wrom_addr, bias_sel, win_row, win_col}), 0);
        chk({tag, "_eng_pix"},   int'(eng_pix != '0), 0);
        chk({tag, "_res_regs"},  int'({res_data, res_filt, res_row, res_col} != '0), 0);
    endtask

    task automatic pulse_start(input string tag);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, int'(busy), 1);
        chk({tag, "_err_cleared"}, int'(err), 0);
    endtask

    task automatic wait_done(input string tag, input int d0);
        int k = 0;
        while (n_done == d0 && k < 3000) begin
            tick();
            k++;
        end
        if (n_done == d0) chk({tag, "_done_wait_expired"}, 0, 1);
        repeat (3) tick();
        chk({tag, "_done_once"}, n_done - d0, 1);
        chk({tag, "_busy_low"}, int'(busy), 0);
    endtask

    task automatic run_frame(input string tag);
        int d0 = n_done;
        pulse_start(tag);
        wait_done(tag, d0);
        chk({tag, "_all_results"}, sb.size(), 0);
    endtask

    task automatic wait_kick(input string tag, input int k0);
        int k = 0;
        while (n_kick == k0 && k < 200) begin
            tick();
            k++;
        end
        if (n_kick == k0) chk({tag, "_kick_wait_expired"}, 0, 1);
    endtask

    initial begin
        vec_t vecs [4];
        int d0, k0, r0, k, bad, sd, sf, sr, sc, w0;

        vecs[0] = '{1,   1,   -1,  0,  5,    9,    -4};
        vecs[1] = '{2,   3,    1, -1,  0,   53,    18};
        vecs[2] = '{0,   5,    5,  7, -7,    7,    -7};
        vecs[3] = '{10, 100, -100, 3,  0, 9003, -9000};

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            for (int r = 0; r < TH; r++)
                for (int c = 0; c < TW; c++) img[r][c] = vecs[v].pix;
            for (int i = 0; i < 9; i++) begin
                wts[i]     = vecs[v].w0;
                wts[9 + i] = vecs[v].w1;
            end
            bias[0] = vecs[v].b0;
            bias[1] = vecs[v].b1;
            sb.delete();
            for (int r = 0; r < OH; r++)
                for (int c = 0; c < OW; c++) begin
                    sb.push_back('{vecs[v].exp0, 0, r, c});
                    sb.push_back('{vecs[v].exp1, 1, r, c});
                end
            w0       = n_winreq;
            log_addr = (v == 0);
            run_frame($sformatf("vec%0d", v));
            log_addr = 1'b0;
            chk("win_req_per_window", n_winreq - w0, OW * OH);
        end
        chk("addr_log_len", addr_q.size(), OW * OH * TF * 9);
        for (int i = 0; i < TF * 9 && i < addr_q.size(); i++)
            chk($sformatf("wrom_addr_seq%0d", i), addr_q[i], i);

        // Stall in OUT with res_ready low for 20 cycles.
        model_fill();
        rdy_force = 1'b1;
        rdy_val   = 1'b0;
        d0 = n_done;
        pulse_start("stall");
        k = 0;
        while (!res_valid && k < 200) begin
            tick();
            k++;
        end
        chk("stall_res_valid", int'(res_valid), 1);
        sd = int'(res_data); sf = int'(res_filt); sr = int'(res_row); sc = int'(res_col);
        k0  = n_kick;
        bad = 0;
        repeat (20) begin
            tick();
            if (!res_valid || int'(res_data) != sd || int'(res_filt) != sf ||
                int'(res_row) != sr || int'(res_col) != sc) bad++;
        end
        chk("stall_stable", bad, 0);
        chk("stall_no_kick", n_kick - k0, 0);
        chk("stall_first_data", sd, (sb.size() > 0) ? sb[0].data : -99999);
        rdy_force = 1'b0;
        wait_kick("stall", k0);
        chk("kick_after_handshake", t_kick - t_hs, 1);
        wait_done("stall", d0);

        // Start while busy, window source 7 cycles late.
        model_fill();
        win_delay = 7;
        d0 = n_done;
        k0 = n_kick;
        pulse_start("late_win");
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_kick("late_win", k0);
        chk("win_req_len", last_req_len, 8);
        chk("kick_after_win_vld", t_kick - t_vld, 1);
        wait_done("late_win", d0);
        chk("late_win_all_results", sb.size(), 0);
        win_delay = 0;

        // Engine that never answers.
        sb.delete();
        eng_dead = 1'b1;
        r0 = n_res;
        d0 = n_done;
        pulse_start("timeout");
        wait_done("timeout", d0);
        chk("timeout_done_latency", t_done - t_kick, 13);
        chk("timeout_err", int'(err), 1);
        chk("timeout_no_result", n_res - r0, 0);
        repeat (5) tick();
        chk("timeout_err_sticky", int'(err), 1);
        eng_dead = 1'b0;
        model_fill();
        run_frame("after_timeout");

        // Reset during MAC of window (1,0).
        model_fill();
        r0 = n_res;
        pulse_start("midrst");
        k = 0;
        while (n_res < r0 + 2 * TF && k < 500) begin
            tick();
            k++;
        end
        chk("midrst_results_before", n_res - r0, 2 * TF);
        k0 = n_kick;
        wait_kick("midrst", k0);
        chk("midrst_in_mac", int'(wrom_en && !eng_valid_in), 1);
        rst_n = 1'b0;
        tick();
        check_zero("midrst");
        rst_n = 1'b1;
        model_fill();
        run_frame("restart");

        // Randomized frames with random backpressure and window latency.
        rdy_rand = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < TH; r++)
                for (int c = 0; c < TW; c++) img[r][c] = int'($urandom_range(0, 255));
            for (int i = 0; i < TF * 9; i++) wts[i] = int'($urandom_range(0, 255)) - 128;
            for (int i = 0; i < TF; i++) bias[i] = int'($urandom_range(0, 2000)) - 1000;
            win_delay = int'($urandom_range(0, 3));
            model_fill();
            run_frame($sformatf("rand%0d", f));
        end
        rdy_rand  = 1'b0;
        win_delay = 0;

        chk("rom_addr_in_range", n_rom_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
